// File: rtl/fft_pingpong_ctrl.sv
// Ping-pong bank steering and FFT core sequencer with run-time transform length,
// dropped-frame (overrun) detection and an end-of-frame pulse.
module fft_pingpong_ctrl #(
   parameter int MAX_LOG2N   = 10,
   parameter int MIN_LOG2N   = 3,
   parameter int SCLR_CYCLES = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 strobe,
   input  logic [3:0]           log2n,
   input  logic                 clear_overrun,
   input  logic                 e_done_fft_core,
   input  logic                 dv_fft_core,
   output logic                 sclr_fft_core,
   output logic                 nfft_we_fft_core,
   output logic [4:0]           nfft_fft_core,
   output logic                 scale_sch_we_fft_core,
   output logic                 start_fft_core,
   output logic                 unload_fft_core,
   output logic                 wr_en_ram_0,
   output logic                 wr_en_ram_1,
   output logic                 sel_ram,
   output logic [MAX_LOG2N-1:0] addr_ram_0,
   output logic [MAX_LOG2N-1:0] addr_ram_1,
   output logic                 frame_done,
   output logic                 overrun
);

   localparam int AW = MAX_LOG2N;
   localparam int CW = MAX_LOG2N + 1;
   localparam int SW = (SCLR_CYCLES > 1) ? $clog2(SCLR_CYCLES) : 1;
   localparam logic [3:0]    MIN_LEN   = 4'(MIN_LOG2N);
   localparam logic [3:0]    MAX_LEN   = 4'(MAX_LOG2N);
   localparam logic [SW-1:0] SCLR_LAST = SW'(SCLR_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLEAR, ST_CONFIG, ST_START, ST_LOAD, ST_WAIT, ST_UNLOAD, ST_OUTPUT
   } state_t;

   function automatic logic [AW-1:0] frame_last(input logic [3:0] len);
      logic [CW-1:0] span;
      span = CW'(1) << len;
      return AW'(span - CW'(1));
   endfunction

   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      logic [3:0] res;
      res = len;
      if (len < MIN_LEN) res = MIN_LEN;
      if (len > MAX_LEN) res = MAX_LEN;
      return res;
   endfunction

   state_t          state_q, state_d;
   logic [SW-1:0]   sclr_cnt_q, sclr_cnt_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [AW-1:0]   dv_cnt_q, dv_cnt_d;
   logic [3:0]      wr_len_q, wr_len_d;
   logic [3:0]      fft_len_q, fft_len_d;
   logic            sel_ram_q, sel_ram_d;
   logic            overrun_q, overrun_d;
   logic            sclr_q, sclr_d;
   logic            nfft_we_q, nfft_we_d;
   logic            start_q, start_d;
   logic            unload_q, unload_d;
   logic [4:0]      nfft_q, nfft_d;

   logic [AW-1:0]   wr_last;
   logic [AW-1:0]   fft_last;
   logic            frame_full;
   logic            last_dv;
   logic            fft_free;
   logic            handoff;
   logic            drop;

   always_comb begin
      state_d    = state_q;
      sclr_cnt_d = sclr_cnt_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dv_cnt_d   = dv_cnt_q;
      wr_len_d   = wr_len_q;
      fft_len_d  = fft_len_q;
      sel_ram_d  = sel_ram_q;
      overrun_d  = overrun_q;
      frame_done = 1'b0;

      wr_last    = frame_last(wr_len_q);
      fft_last   = frame_last(fft_len_q);
      frame_full = strobe && (wr_addr_q == wr_last);
      last_dv    = (state_q == ST_OUTPUT) && dv_fft_core && (dv_cnt_q == fft_last);
      // A transform finishing in the same cycle still frees the core for the new frame
      fft_free   = (state_q == ST_IDLE) || last_dv;
      handoff    = frame_full && fft_free;
      drop       = frame_full && !fft_free;

      if (strobe) begin
         if (wr_addr_q == '0) wr_len_d = clamp_len(log2n);
         wr_addr_d = frame_full ? '0 : wr_addr_q + 1'b1;
      end

      case (state_q)
         ST_CLEAR: begin
            if (sclr_cnt_q == SCLR_LAST) state_d = ST_CONFIG;
            else sclr_cnt_d = sclr_cnt_q + 1'b1;
         end
         ST_CONFIG: begin
            state_d   = ST_START;
            rd_addr_d = '0;
         end
         ST_START: state_d = ST_LOAD;
         ST_LOAD: begin
            if (rd_addr_q == fft_last) state_d = ST_WAIT;
            else rd_addr_d = rd_addr_q + 1'b1;
         end
         ST_WAIT: begin
            if (e_done_fft_core) state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            dv_cnt_d = '0;
            state_d  = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (last_dv) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end else if (dv_fft_core) begin
               dv_cnt_d = dv_cnt_q + 1'b1;
            end
         end
         default: state_d = state_q;
      endcase

      if (handoff) begin
         sel_ram_d  = ~sel_ram_q;
         fft_len_d  = wr_len_q;
         state_d    = ST_CLEAR;
         sclr_cnt_d = '0;
      end

      // A drop in the same cycle as a clear request keeps the flag set
      if (drop) overrun_d = 1'b1;
      else if (clear_overrun) overrun_d = 1'b0;

      sclr_d    = (state_d == ST_CLEAR);
      nfft_we_d = (state_d == ST_CONFIG);
      start_d   = (state_d == ST_START);
      unload_d  = (state_d == ST_UNLOAD);
      nfft_d    = (state_d == ST_CONFIG) ? {1'b0, fft_len_q} : nfft_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         sclr_cnt_q <= '0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dv_cnt_q   <= '0;
         wr_len_q   <= MIN_LEN;
         fft_len_q  <= MIN_LEN;
         sel_ram_q  <= 1'b0;
         overrun_q  <= 1'b0;
         sclr_q     <= 1'b0;
         nfft_we_q  <= 1'b0;
         start_q    <= 1'b0;
         unload_q   <= 1'b0;
         nfft_q     <= 5'(MIN_LOG2N);
      end else begin
         state_q    <= state_d;
         sclr_cnt_q <= sclr_cnt_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dv_cnt_q   <= dv_cnt_d;
         wr_len_q   <= wr_len_d;
         fft_len_q  <= fft_len_d;
         sel_ram_q  <= sel_ram_d;
         overrun_q  <= overrun_d;
         sclr_q     <= sclr_d;
         nfft_we_q  <= nfft_we_d;
         start_q    <= start_d;
         unload_q   <= unload_d;
         nfft_q     <= nfft_d;
      end
   end

   assign sclr_fft_core         = sclr_q;
   assign nfft_we_fft_core      = nfft_we_q;
   assign scale_sch_we_fft_core = nfft_we_q;
   assign nfft_fft_core         = nfft_q;
   assign start_fft_core        = start_q;
   assign unload_fft_core       = unload_q;
   assign sel_ram               = sel_ram_q;
   assign overrun               = overrun_q;
   assign wr_en_ram_0           = strobe & ~sel_ram_q;
   assign wr_en_ram_1           = strobe & sel_ram_q;
   assign addr_ram_0            = sel_ram_q ? rd_addr_q : wr_addr_q;
   assign addr_ram_1            = sel_ram_q ? wr_addr_q : rd_addr_q;

endmodule
